// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-sweeps r1..NREGS-1 after reset/clear, then
// round-robin arbitrates ALU (A) and load (B) writebacks onto the single write port.
module regfile_wb_arbiter #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          RegWrite,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData,
    output logic          init_done
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [AW-1:0] FirstReg = AW'(1);
    localparam logic [AW-1:0] LastReg  = AW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_b_q, last_b_d;
    logic          we_q, we_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          done_q, done_d;

    logic run_ok;
    logic grant_a;
    logic grant_b;

    // On contention the side that was not served last wins.
    assign run_ok  = (state_q == StRun) && !clear;
    assign grant_a = run_ok && a_valid && (!b_valid || last_b_q);
    assign grant_b = run_ok && b_valid && (!a_valid || !last_b_q);

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign RegWrite  = we_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;
    assign init_done = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        if (clear) begin
            state_d = StInit;
            cnt_d   = FirstReg;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    we_d    = 1'b1;
                    wreg_d  = cnt_q;
                    wdata_d = '0;
                    if (cnt_q == LastReg) begin
                        state_d = StRun;
                        cnt_d   = FirstReg;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + FirstReg;
                    end
                end
                StRun: begin
                    // Writes to r0 complete the handshake but are dropped.
                    if (grant_a) begin
                        last_b_d = 1'b0;
                        if (a_addr != '0) begin
                            we_d    = 1'b1;
                            wreg_d  = a_addr;
                            wdata_d = a_data;
                        end
                    end else if (grant_b) begin
                        last_b_d = 1'b1;
                        if (b_addr != '0) begin
                            we_d    = 1'b1;
                            wreg_d  = b_addr;
                            wdata_d = b_data;
                        end
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StInit;
            cnt_q    <= FirstReg;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued when a grant is
// expected and popped by a monitor when RegWrite fires.
module tb_regfile_wb_arbiter;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          init_done;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    regfile_wb_arbiter #(
        .NREGS(NREGS),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered write port is compared against the scoreboard one step after each edge.
    always @(posedge clk) begin
        #1;
        if (mon_en && RegWrite === 1'b1) begin
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(WriteReg), 32'(e.addr));
                chk("wr_data", WriteData, e.data);
                chk("wr_init_done", 32'(init_done), 32'd1);
            end
        end
    end

    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic ea, input logic eb);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        if (ea && aa != '0) exp_q.push_back('{addr: aa, data: ad});
        if (eb && ba != '0) exp_q.push_back('{addr: ba, data: bd});
    endtask

    task automatic sweep_check(input int last, input bit a_held);
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #2;
            chk("sweep_we", 32'(RegWrite), 32'd1);
            chk("sweep_addr", 32'(WriteReg), 32'(i));
            chk("sweep_data", WriteData, 32'd0);
            chk("sweep_done", 32'(init_done), 32'(i == int'(NREGS - 1)));
            chk("sweep_a_ready", 32'(a_ready), 32'(a_held && i == int'(NREGS - 1)));
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_we", 32'(RegWrite), 32'd0);
        chk("rst_addr", 32'(WriteReg), 32'd0);
        chk("rst_data", WriteData, 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);

        // Reset in the middle of the sweep, then a full sweep from r1.
        @(negedge clk) rst = 1'b1;
        sweep_check(10, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_we", 32'(RegWrite), 32'd0);
        chk("midrst_done", 32'(init_done), 32'd0);
        chk("midrst_addr", 32'(WriteReg), 32'd0);
        @(negedge clk) rst = 1'b1;
        sweep_check(NREGS - 1, 1'b0);
        mon_en = 1'b1;

        // Contention straight after reset: A first, then alternate.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Single A request, then idle: outputs hold with RegWrite low.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("idle_we", 32'(RegWrite), 32'd0);
        chk("idle_addr", 32'(WriteReg), 32'd5);
        chk("idle_data", WriteData, 32'hDEADBEEF);

        // B writes r0: accepted but dropped, and it becomes last_grant.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("r0_we", 32'(RegWrite), 32'd0);
        chk("r0_addr", 32'(WriteReg), 32'd5);
        step(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Clear with A pending: no grant, sweep reruns, A held off until done.
        @(negedge clk);
        mon_en = 1'b0;
        clear = 1'b1; a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
        #1;
        chk("clear_a_ready", 32'(a_ready), 32'd0);
        @(posedge clk);
        #2;
        chk("clear_we", 32'(RegWrite), 32'd0);
        chk("clear_done", 32'(init_done), 32'd0);
        @(negedge clk) clear = 1'b0;
        #1;
        chk("clear_hold_a_ready", 32'(a_ready), 32'd0);
        sweep_check(NREGS - 1, 1'b1);
        a_valid = 1'b0;
        mon_en = 1'b1;
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
